mux2_arbiter: RTL and testbench

// - Round-robin arbiter that shares one mux2 datapath between two requesters.
// - Drives the mux2 Select line and grants ownership of the shared output Z.
// - Grant length is bounded. Each grant is followed by a turnaround gap, so

---
 rtl/mux2_arb_pkg.sv | 6 +
 rtl/mux2_arb_if.sv | 11 +
 rtl/arb_hold_timer.sv | 17 +
 rtl/mux2_arbiter.sv | 74 +++++++
 tb/tb_mux2_arbiter.sv | 123 ++++++++++++
 5 files changed

// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared state encoding and default timing constants for the mux2 arbiter
package mux2_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_GAP_CYCLES = 1;
endpackage

// File: rtl/mux2_arb_if.sv
// mux2_arb_if: requester/arbiter bundle; master drives Req/Done, slave (arbiter) drives Grant/Select/Busy
interface mux2_arb_if;
  import mux2_arb_pkg::*;
  logic [1:0] Req;
  logic [1:0] Done;
  logic [1:0] Grant;
  logic       Select;
  logic       Busy;
  modport master (output Req, Done, input Grant, Select, Busy);
  modport slave (input Req, Done, output Grant, Select, Busy);
endinterface

// File: rtl/arb_hold_timer.sv
// arb_hold_timer: clear/increment counter with terminal-count flag; saturates at TC so it never wraps (ports: clk, rst, load, inc -> tc)
module arb_hold_timer #(
  parameter int W  = 5,
  parameter int TC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(TC);
  always_ff @(posedge clk)
    if (rst || load) cnt <= '0;
    else if (inc && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin owner of a shared mux2 with bounded grants and a turnaround gap (ports: Clk, Reset, bus.Req/Done in, bus.Grant/Select/Busy out, all registered)
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic       Clk,
  input logic       Reset,
  mux2_arb_if.slave bus
);
  localparam int HW  = $clog2(MAX_HOLD) + 1;
  localparam int GTC = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  state_t     state, state_d;
  logic [1:0] grant_d;
  logic       sel_d, busy_d, last, last_d, hold_tc, gap_tc, g, win, rel;
  // the granted index is whatever Select currently routes
  assign g   = bus.Select;
  assign win = &bus.Req ? ~last : bus.Req[1];
  assign rel = bus.Done[g] || !bus.Req[g] || hold_tc;
  arb_hold_timer #(.W(HW), .TC(MAX_HOLD - 1)) u_hold (
    .clk(Clk), .rst(Reset), .load(state != GRANT), .inc(state == GRANT), .tc(hold_tc)
  );
  arb_hold_timer #(.W(3), .TC(GTC)) u_gap (
    .clk(Clk), .rst(Reset), .load(state != GAP), .inc(state == GAP), .tc(gap_tc)
  );
  always_ff @(posedge Clk)
    if (Reset) begin
      state      <= IDLE;
      bus.Grant  <= '0;
      bus.Select <= 1'b0;
      bus.Busy   <= 1'b0;
      last       <= 1'b1;
    end else begin
      state      <= state_d;
      bus.Grant  <= grant_d;
      bus.Select <= sel_d;
      bus.Busy   <= busy_d;
      last       <= last_d;
    end
  always_comb begin
    state_d = state;
    grant_d = bus.Grant;
    sel_d   = bus.Select;
    busy_d  = bus.Busy;
    last_d  = last;
    case (state)
      IDLE:
        if (|bus.Req) begin
          state_d = GRANT;
          grant_d = win ? 2'b10 : 2'b01;
          sel_d   = win;
          busy_d  = 1'b1;
        end
      GRANT:
        if (rel) begin
          state_d = GAP_CYCLES > 0 ? GAP : IDLE;
          grant_d = '0;
          busy_d  = GAP_CYCLES > 0;
          last_d  = g;
        end
      GAP:
        if (gap_tc) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: random and directed stimulus on two arbiter configurations checked against an ownership/cooldown model
module tb_mux2_arbiter;
  import mux2_arb_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  int         nchk = 0;
  int         nerr = 0;
  int         p_max [2];
  int         p_gap [2];
  int         m_own [2];
  int         m_cnt [2];
  int         m_cool[2];
  bit         m_last[2];
  bit         m_sel [2];
  logic [1:0] dg [2];
  logic       ds [2];
  logic       db [2];
  mux2_arb_if if0 ();
  mux2_arb_if if1 ();
  assign if0.Req  = req;
  assign if0.Done = done;
  assign if1.Req  = req;
  assign if1.Done = done;
  mux2_arbiter u_dut0 (.Clk(clk), .Reset(rst), .bus(if0.slave));
  mux2_arbiter #(.MAX_HOLD(5), .GAP_CYCLES(0)) u_dut1 (.Clk(clk), .Reset(rst), .bus(if1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  // one clock: apply inputs, advance the model on the edge, compare both DUTs just after it
  task automatic cyc(input logic [1:0] r, input logic [1:0] d, input logic rs);
    req = r;
    done = d;
    rst = rs;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_own[k] = -1; m_cnt[k] = 0; m_cool[k] = 0; m_last[k] = 1'b1; m_sel[k] = 1'b0;
      end else if (m_own[k] >= 0) begin
        m_cnt[k]++;
        if (d[m_own[k]] || !r[m_own[k]] || m_cnt[k] == p_max[k]) begin
          m_last[k] = m_own[k][0];
          m_own[k] = -1;
          m_cool[k] = p_gap[k];
        end
      end else if (m_cool[k] > 0) m_cool[k]--;
      else if (r != 2'b00) begin
        m_own[k] = (r == 2'b11) ? int'(!m_last[k]) : int'(r[1]);
        m_sel[k] = m_own[k][0];
        m_cnt[k] = 0;
      end
    end
    #1;
    dg[0] = if0.Grant; ds[0] = if0.Select; db[0] = if0.Busy;
    dg[1] = if1.Grant; ds[1] = if1.Select; db[1] = if1.Busy;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("grant%0d", k), 8'(dg[k]), m_own[k] < 0 ? 8'd0 : 8'(1 << m_own[k]));
      chk($sformatf("select%0d", k), 8'(ds[k]), 8'(m_sel[k]));
      chk($sformatf("busy%0d", k), 8'(db[k]), 8'(m_own[k] >= 0 || m_cool[k] > 0));
    end
  endtask
  initial begin
    int  run;
    bit  ended;
    logic [1:0] r, d;
    p_max[0] = DEF_MAX_HOLD; p_gap[0] = DEF_GAP_CYCLES;
    p_max[1] = 5;            p_gap[1] = 0;
    cyc(2'b11, 2'b00, 1'b1);
    cyc(2'b11, 2'b00, 1'b1);
    chk("rst_grant", 8'(if0.Grant), 8'h0);
    chk("rst_sel", 8'(if0.Select), 8'h0);
    chk("rst_busy", 8'(if0.Busy), 8'h0);
    cyc(2'b11, 2'b00, 1'b0);
    chk("first_grant", 8'(if0.Grant), 8'h1);
    chk("first_busy", 8'(if0.Busy), 8'h1);
    cyc(2'b11, 2'b01, 1'b0);
    chk("gap_grant", 8'(if0.Grant), 8'h0);
    chk("gap_sel", 8'(if0.Select), 8'h0);
    cyc(2'b11, 2'b00, 1'b0);
    chk("idle_grant", 8'(if0.Grant), 8'h0);
    chk("idle_sel", 8'(if0.Select), 8'h0);
    cyc(2'b11, 2'b00, 1'b0);
    chk("rr_grant", 8'(if0.Grant), 8'h2);
    chk("rr_sel", 8'(if0.Select), 8'h1);
    cyc(2'b01, 2'b00, 1'b1);
    run = 0;
    ended = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(2'b01, 2'b00, 1'b0);
      if (if0.Grant == 2'b01 && !ended) run++;
      else if (run > 0) ended = 1;
    end
    chk("hold_len", 8'(run), 8'(DEF_MAX_HOLD));
    cyc(2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc({i[0], 1'b1}, 2'b10, 1'b0);
      chk("ignore_other", 8'(if0.Grant), 8'h1);
    end
    cyc(2'b11, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(2'b10, 2'b00, 1'b0);
    chk("mid_pre", 8'(if0.Grant), 8'h2);
    cyc(2'b10, 2'b00, 1'b1);
    chk("mid_rst_grant", 8'(if0.Grant), 8'h0);
    chk("mid_rst_busy", 8'(if0.Busy), 8'h0);
    cyc(2'b11, 2'b00, 1'b0);
    chk("mid_rst_last", 8'(if0.Grant), 8'h1);
    r = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) r[0] = ~r[0];
      if ($urandom_range(5) == 0) r[1] = ~r[1];
      d = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
      cyc(r, d, $urandom_range(249) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
